// File: rtl/Util.sv
// Shared numeric types for the complex FPU datapath.
// floatType is a signed Q16.16 fixed-point scalar; complex pairs two of them.
package Util;

  localparam int FLOAT_W = 32;
  localparam int FRAC_W  = 16;

  typedef logic signed [FLOAT_W-1:0] floatType;

  typedef struct packed {
    floatType re;
    floatType im;
  } complex;

  typedef enum logic {
    ADD  = 1'b0,
    MULT = 1'b1
  } FPU_opcode;

  // Full-width product, then drop the extra fraction bits (truncation toward -inf).
  function automatic floatType f_mul(input floatType a, input floatType b);
    logic signed [2*FLOAT_W-1:0] p;
    p = a * b;
    return floatType'(p >>> FRAC_W);
  endfunction

endpackage

// File: rtl/CFPU.sv
// Combinational complex arithmetic unit; OP selects a complex add or multiply.
module CFPU
  import Util::*;
#(
  parameter FPU_opcode OP = MULT
) (
  input  complex a,
  input  complex b,
  output complex y
);

  generate
    if (OP == MULT) begin : g_mult
      assign y = '{re: f_mul(a.re, b.re) - f_mul(a.im, b.im),
                   im: f_mul(a.re, b.im) + f_mul(a.im, b.re)};
    end else begin : g_add
      assign y = '{re: a.re + b.re,
                   im: a.im + b.im};
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: scans from ptr upward (mod N_REQ) and grants the first request.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W:0] N_REQ_W = (IDX_W+1)'(N_REQ);

  logic [IDX_W:0] cand;
  logic           found;

  // One extra bit on cand holds ptr+k before the modulo wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= N_REQ_W) cand = cand - N_REQ_W;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                      = 1'b1;
        grant[cand[IDX_W-1:0]]     = 1'b1;
        grant_idx                  = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cfpu_arbiter.sv
// Shares one complex FPU between N_REQ requesters with round-robin arbitration
// and a single registered result slot (1-cycle latency, full throughput).
module cfpu_arbiter
  import Util::*;
#(
  parameter int        N_REQ = 4,
  parameter FPU_opcode OP    = MULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  complex                   req_A [N_REQ],
  input  complex                   req_B [N_REQ],
  output logic                     res_valid,
  input  logic                     res_ready,
  output complex                   res_data,
  output logic [$clog2(N_REQ)-1:0] res_id
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             slot_free;
  logic             grant_any;
  complex           op_a;
  complex           op_b;
  complex           cfpu_y;

  logic [IDX_W-1:0] ptr_d, ptr_q;
  logic [IDX_W-1:0] res_id_d, res_id_q;
  logic             res_valid_d, res_valid_q;
  complex           res_data_d, res_data_q;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Handshake: a transfer happens on any cycle where valid and ready are both 1.
  // The slot accepts a new pair when empty or being drained this same cycle;
  // ready is held low throughout reset.
  assign slot_free = rst & (~res_valid_q | res_ready);
  assign req_ready = grant & {N_REQ{slot_free}};
  assign grant_any = |req_ready;

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        op_a = req_A[i];
        op_b = req_B[i];
      end
    end
  end

  CFPU #(
    .OP(OP)
  ) u_cfpu (
    .a (op_a),
    .b (op_b),
    .y (cfpu_y)
  );

  always_comb begin
    ptr_d       = ptr_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q & ~res_ready;
    if (grant_any) begin
      ptr_d       = (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
      res_id_d    = grant_idx;
      res_data_d  = cfpu_y;
      res_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_cfpu_arbiter.sv
// Bench for cfpu_arbiter: a MULT and an ADD instance share stimulus and are
// compared against a real-arithmetic round-robin reference model.
module tb_cfpu_arbiter;
  import Util::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready, req_ready_add;
  complex       req_A [N];
  complex       req_B [N];
  logic         res_ready;
  logic         res_valid, res_valid_add;
  complex       res_data, res_data_add;
  logic [1:0]   res_id, res_id_add;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int     m_ptr;
  bit     m_pend;
  complex m_mul;
  complex m_add;
  int     m_id;
  int     last_g;
  int     wait_cnt [N];

  typedef struct {
    logic [N-1:0] v;
    logic         rr;
    int           exp_g;
  } vec_t;

  vec_t tbl [16];

  cfpu_arbiter #(.N_REQ(N), .OP(MULT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_A     (req_A),
    .req_B     (req_B),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  cfpu_arbiter #(.N_REQ(N), .OP(ADD)) dut_add (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready_add),
    .req_A     (req_A),
    .req_B     (req_B),
    .res_valid (res_valid_add),
    .res_ready (res_ready),
    .res_data  (res_data_add),
    .res_id    (res_id_add)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic real to_real(input floatType x);
    return real'(x) / 65536.0;
  endfunction

  function automatic floatType to_fix(input real r);
    return floatType'($rtoi(r * 65536.0));
  endfunction

  function automatic complex ref_op(input FPU_opcode op, input complex a, input complex b);
    real ar, ai, br, bi, yr, yi;
    complex y;
    ar = to_real(a.re); ai = to_real(a.im);
    br = to_real(b.re); bi = to_real(b.im);
    if (op == MULT) begin
      yr = ar * br - ai * bi;
      yi = ar * bi + ai * br;
    end else begin
      yr = ar + br;
      yi = ai + bi;
    end
    y.re = to_fix(yr);
    y.im = to_fix(yi);
    return y;
  endfunction

  // Quarter-step values in [-16,16]: every product is exact in Q16.16.
  function automatic floatType rand_val();
    int k;
    k = int'($urandom_range(128)) - 64;
    return floatType'(k * 16384);
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_pend = 0;
    m_mul  = '0;
    m_add  = '0;
    m_id   = 0;
    last_g = -1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  // Drives one cycle starting just after a rising edge, checks at the falling edge.
  task automatic do_cycle(input logic [N-1:0] v, input logic rr);
    int g;
    int idx;
    logic [N-1:0] exp_rdy;
    req_valid = v;
    res_ready = rr;
    @(negedge clk);
    g = -1;
    if (!m_pend || rr) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    check("req_ready_add", req_ready_add, exp_rdy);
    check("res_valid", res_valid, m_pend);
    check("res_valid_add", res_valid_add, m_pend);
    check("res_id", res_id, m_id);
    check("res_id_add", res_id_add, m_id);
    check("res_data_mul", res_data, m_mul);
    check("res_data_add", res_data_add, m_add);
    if (g >= 0) begin
      for (int i = 0; i < N; i++) begin
        if (i == g || !v[i]) wait_cnt[i] = 0;
        else begin
          wait_cnt[i]++;
          check("no_starve", wait_cnt[i] < N, 1'b1);
        end
      end
      m_mul  = ref_op(MULT, req_A[g], req_B[g]);
      m_add  = ref_op(ADD, req_A[g], req_B[g]);
      m_id   = g;
      m_pend = 1;
      m_ptr  = (g + 1) % N;
    end else if (rr) begin
      m_pend = 0;
    end
    for (int i = 0; i < N; i++) if (!v[i]) wait_cnt[i] = 0;
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    complex e;

    tbl[0]  = '{4'b1111, 1'b1, 0};
    tbl[1]  = '{4'b1111, 1'b1, 1};
    tbl[2]  = '{4'b1111, 1'b1, 2};
    tbl[3]  = '{4'b1111, 1'b1, 3};
    tbl[4]  = '{4'b1111, 1'b1, 0};
    tbl[5]  = '{4'b1111, 1'b1, 1};
    tbl[6]  = '{4'b1111, 1'b1, 2};
    tbl[7]  = '{4'b1010, 1'b1, 3};
    tbl[8]  = '{4'b1010, 1'b1, 1};
    tbl[9]  = '{4'b0001, 1'b0, -1};
    tbl[10] = '{4'b0001, 1'b0, -1};
    tbl[11] = '{4'b0001, 1'b0, -1};
    tbl[12] = '{4'b0001, 1'b1, 0};
    tbl[13] = '{4'b0000, 1'b1, -1};
    tbl[14] = '{4'b0000, 1'b0, -1};
    tbl[15] = '{4'b0000, 1'b0, -1};

    // Clock/reset
    rst       = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_A[i] = '{re: floatType'((i + 1) * 65536), im: floatType'(0)};
      req_B[i] = '{re: floatType'(131072), im: floatType'(65536)};
    end
    model_reset();
    #1;
    req_valid = '1;
    res_ready = 1'b1;
    #3;
    check("rst_req_ready", req_ready, '0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_id", res_id, 2'd0);
    check("rst_res_data", res_data, '0);
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b1;
    @(posedge clk);
    #1;

    // Table: all-valid rotation, wrap from ptr=3, stall then same-cycle refill
    for (int i = 0; i < 16; i++) begin
      do_cycle(tbl[i].v, tbl[i].rr);
      check("tbl_grant", last_g, tbl[i].exp_g);
    end

    // Single requester MULT: (1+2i)(3+4i) = -5+10i
    req_A[2] = '{re: floatType'(65536), im: floatType'(131072)};
    req_B[2] = '{re: floatType'(196608), im: floatType'(262144)};
    do_cycle(4'b0100, 1'b1);
    check("s1_grant", last_g, 2);
    e.re = floatType'(-327680);
    e.im = floatType'(655360);
    check("s1_res_valid", res_valid, 1'b1);
    check("s1_res_data", res_data, e);
    check("s1_res_id", res_id, 2'd2);

    // ADD: (1.5-2i)+(0.5+2i) = 2+0i
    req_A[0] = '{re: floatType'(98304), im: floatType'(-131072)};
    req_B[0] = '{re: floatType'(32768), im: floatType'(131072)};
    do_cycle(4'b0001, 1'b1);
    check("s5_grant", last_g, 0);
    e.re = floatType'(131072);
    e.im = floatType'(0);
    check("s5_res_data", res_data_add, e);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < N; i++) begin
        req_A[i] = '{re: rand_val(), im: rand_val()};
        req_B[i] = '{re: rand_val(), im: rand_val()};
      end
      do_cycle(4'($urandom_range(15)), $urandom_range(3) != 0);
    end
    do_cycle(4'b0000, 1'b1);

    // Reset asserted during a stalled result
    do_cycle(4'b0100, 1'b1);
    check("s6_pre_grant", last_g, 2);
    req_valid = 4'b0010;
    res_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("s6_res_valid", res_valid, 1'b0);
    check("s6_req_ready", req_ready, '0);
    check("s6_res_data", res_data, '0);
    check("s6_res_id", res_id, 2'd0);
    model_reset();
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_cycle(4'b0110, 1'b1);
    check("s6_grant", last_g, 1);
    do_cycle(4'b0110, 1'b1);
    check("s6_grant2", last_g, 2);
    do_cycle(4'b0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cfpu_arbiter.md
CFPU_ARBITER -- requirements
Module: cfpu_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one complex FPU (range 2..16).
REQ-002 The block SHALL have parameter OP, type FPU_opcode, default MULT, giving the operation of the shared complex unit (ADD or MULT).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, N_REQ bits: requester i presents an operand pair.
REQ-006 The block SHALL have port req_ready, output, N_REQ bits: requester i's pair is accepted this cycle.
REQ-007 The block SHALL have port req_A, input, N_REQ x complex: first operand per requester.
REQ-008 The block SHALL have port req_B, input, N_REQ x complex: second operand per requester.
REQ-009 The block SHALL have port res_valid, output, 1 bit: res_data and res_id hold a result.
REQ-010 The block SHALL have port res_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-011 The block SHALL have port res_data, output, complex: the registered result.
REQ-012 The block SHALL have port res_id, output, $clog2(N_REQ) bits: index of the requester that produced res_data.

Function
REQ-013 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1; a result transfer SHALL occur where res_valid and res_ready are both 1.
REQ-014 At most one req_ready bit SHALL be 1 per cycle; req_ready[i] SHALL be 1 only if req_valid[i] is 1 and the output slot is free.
REQ-015 The output slot SHALL be free when res_valid is 0, or when res_valid and res_ready are both 1 (drain and refill in the same cycle).
REQ-016 Arbitration SHALL be round-robin: search starts at pointer ptr and increments modulo N_REQ; the first index with req_valid set is granted.
REQ-017 On a grant to index g, ptr SHALL become (g+1) mod N_REQ at the next edge, wrapping from N_REQ-1 to 0; ptr SHALL hold when nothing is granted.
REQ-018 The granted req_A and req_B SHALL drive one shared CFPU #(OP); its output SHALL be registered into res_data, with g registered into res_id, at the grant edge.
REQ-019 Latency SHALL be 1 cycle: a grant at edge t SHALL give res_valid=1 after edge t; sustained throughput SHALL be one result per cycle while res_ready=1.
REQ-020 While res_valid=1 and res_ready=0, res_data, res_id and res_valid SHALL hold, and all req_ready SHALL be 0.
REQ-021 When the slot drains with no grant, res_valid SHALL go to 0 at the next edge; res_data and res_id SHALL keep their last values.
REQ-022 A requester holding req_valid SHALL be granted within N_REQ grants (no starvation).
REQ-023 req_ready SHALL be combinational from req_valid, ptr, res_valid and res_ready; no other output SHALL be combinational from inputs.

Reset
REQ-024 While rst=0, res_valid, res_data (all fields), res_id and ptr SHALL be 0, and req_ready SHALL be all 0.
REQ-025 Assertion of rst during a stalled result SHALL discard it; the first grant after release SHALL start the search at index 0.

Structure
REQ-026 The complex, floatType and FPU_opcode types SHALL come from the shared Util package; no new typedefs SHALL be defined locally.
REQ-027 The datapath SHALL be exactly one CFPU instance; the round-robin grant logic SHALL be the sub-module rr_arbiter (parameter N_REQ; inputs req and ptr; outputs grant one-hot and grant index).

Verification
REQ-028 Scenario 1: OP=MULT, only req 2 valid, A=1+2i, B=3+4i, res_ready=1 -> req_ready[2]=1 in the same cycle; next cycle res_valid=1, res_data=-5+10i, res_id=2.
REQ-029 Scenario 2: all 4 requesters valid continuously, res_ready=1, ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; res_id follows one cycle later.
REQ-030 Scenario 3: result pending, res_ready=0 for 3 cycles with req 0 valid -> req_ready=0, res_data and res_id stable; on the cycle res_ready=1, req 0 is granted in the same cycle.
REQ-031 Scenario 4: ptr=3, only reqs 1 and 3 valid -> grant 3, ptr wraps to 0, next grant 1.
REQ-032 Scenario 5: OP=ADD, A=1.5-2i, B=0.5+2i -> res_data=2+0i.
REQ-033 Scenario 6: rst=0 asserted mid-stall -> res_valid=0 immediately (asynchronous); after release, reqs 1 and 2 valid -> grant 1 first.
